// File: rtl/uart_rx_buffered_if.sv
// uart_rx_buffered_if
// Purpose : bundles the consumer-side signals of the buffered UART receiver so
//           the receiver and its consumer share one connection.
// Signals : data       - head-of-FIFO received word
//           parity_err - parity error flag of the head entry
//           frame_err  - stop-bit error flag of the head entry
//           valid      - FIFO non-empty, head entry presented
//           ready      - consumer accepts the head entry when valid && ready
//           overrun    - one-cycle pulse when a completed frame is dropped
//           count      - current FIFO occupancy
// Modports: master - the receiver (drives everything except ready)
//           slave  - the consumer (drives ready)
interface uart_rx_buffered_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);
   logic [WIDTH-1:0]         data;
   logic                     parity_err;
   logic                     frame_err;
   logic                     valid;
   logic                     ready;
   logic                     overrun;
   logic [$clog2(DEPTH):0]   count;

   modport master (
      output data, parity_err, frame_err, valid, overrun, count,
      input  ready
   );

   modport slave (
      input  data, parity_err, frame_err, valid, overrun, count,
      output ready
   );
endinterface

// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered
// Purpose : UART receiver with majority-vote bit sampling, optional parity,
//           1 or 2 checked stop bits, and a show-ahead FIFO of received words
//           together with their parity/frame error flags.
// Ports   : clock - single clock, rising edge
//           reset - asynchronous active-high reset
//           rx    - asynchronous serial line, idle high
//           bus   - consumer interface (data, parity_err, frame_err, valid,
//                   ready, overrun, count)
module uart_rx_buffered #(
   parameter int WIDTH      = 8,
   parameter int CLOCK_FREQ = 460800,
   parameter int BAUD_RATE  = 9600,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int DEPTH      = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               rx,
   uart_rx_buffered_if.master bus
);
   localparam int TICKS = CLOCK_FREQ / BAUD_RATE;
   localparam int CW    = $clog2(TICKS);
   localparam int AW    = $clog2(DEPTH);
   localparam int BW    = $clog2(WIDTH);

   localparam logic [CW-1:0] MID_LO   = CW'(TICKS / 2 - 1);
   localparam logic [CW-1:0] MID      = CW'(TICKS / 2);
   localparam logic [CW-1:0] MID_HI   = CW'(TICKS / 2 + 1);
   localparam logic [CW-1:0] LAST     = CW'(TICKS - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
   localparam logic          LAST_STP = 1'(STOP_BITS - 1);
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY_BIT,
      STOP,
      WAIT_IDLE
   } stateT;

   stateT              state;
   stateT              nextState;
   logic               syncA;
   logic               syncB;
   logic               rxSync;
   logic [CW-1:0]      tick;
   logic [BW-1:0]      bitIdx;
   logic               stopIdx;
   logic               sampA;
   logic               sampB;
   logic               majority;
   logic [WIDTH-1:0]   shiftReg;
   logic               parErr;
   logic               frmErr;
   logic               frameDone;
   logic               pushPending;
   logic               atMidHi;
   logic               atLast;

   logic [WIDTH+1:0]   mem [DEPTH];
   logic [WIDTH+1:0]   headWord;
   logic [AW-1:0]      wrPtr;
   logic [AW-1:0]      rdPtr;
   logic [AW:0]        cnt;
   logic               overrunReg;
   logic               fifoValid;
   logic               fifoFull;
   logic               pop;
   logic               pushOk;

   assign rxSync   = syncB;
   assign atMidHi  = (tick == MID_HI);
   assign atLast   = (tick == LAST);
   // The third vote is the live sample taken on the MID_HI cycle itself.
   assign majority = (sampA & sampB) | (sampA & rxSync) | (sampB & rxSync);

   // Two-flop synchronizer for the asynchronous serial line; resets to the
   // idle level so that reset release never looks like a start bit.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         syncA <= 1'b1;
         syncB <= 1'b1;
      end else begin
         syncA <= rx;
         syncB <= syncA;
      end
   end

   // Receiver state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic. A frame completes at the vote point of its last stop
   // bit rather than at the end of that bit, which leaves room for a start
   // bit that follows immediately. A low line at that point is a break, so
   // the receiver waits for the line to go high before hunting again.
   always_comb begin
      nextState = state;
      frameDone = 1'b0;
      case (state)
         IDLE: begin
            if (!rxSync) nextState = START;
         end
         START: begin
            if (atMidHi && majority) nextState = IDLE;
            else if (atLast)         nextState = DATA;
         end
         DATA: begin
            if (atLast && bitIdx == LAST_BIT)
               nextState = (PARITY != 0) ? PARITY_BIT : STOP;
         end
         PARITY_BIT: begin
            if (atLast) nextState = STOP;
         end
         STOP: begin
            if (atMidHi && stopIdx == LAST_STP) begin
               frameDone = 1'b1;
               nextState = rxSync ? IDLE : WAIT_IDLE;
            end
         end
         WAIT_IDLE: begin
            if (rxSync) nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   // Bit timing, vote sampling, data shifting and error accumulation. The
   // tick counter is held at zero while idle so a detected start edge begins
   // counting from zero. The push is delayed one cycle after frame completion
   // so that the error flags updated at the vote point are already settled.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tick        <= '0;
         bitIdx      <= '0;
         stopIdx     <= 1'b0;
         sampA       <= 1'b0;
         sampB       <= 1'b0;
         shiftReg    <= '0;
         parErr      <= 1'b0;
         frmErr      <= 1'b0;
         pushPending <= 1'b0;
      end else begin
         pushPending <= frameDone;
         if (state == IDLE || state == WAIT_IDLE) begin
            tick <= '0;
         end else begin
            tick <= atLast ? '0 : tick + 1'b1;
         end
         if (tick == MID_LO) sampA <= rxSync;
         if (tick == MID)    sampB <= rxSync;
         case (state)
            IDLE: begin
               bitIdx  <= '0;
               stopIdx <= 1'b0;
               parErr  <= 1'b0;
               frmErr  <= 1'b0;
            end
            DATA: begin
               if (atMidHi) shiftReg <= {majority, shiftReg[WIDTH-1:1]};
               if (atLast)  bitIdx   <= bitIdx + 1'b1;
            end
            PARITY_BIT: begin
               if (atMidHi) begin
                  parErr <= (PARITY == 2) ? ~(majority ^ (^shiftReg))
                                          :  (majority ^ (^shiftReg));
               end
            end
            STOP: begin
               if (atMidHi && !majority) frmErr  <= 1'b1;
               if (atLast)               stopIdx <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign fifoValid = (cnt != '0);
   assign fifoFull  = (cnt == FULL_CNT);
   assign pop       = fifoValid && bus.ready;
   // A full FIFO still takes the new word when the head leaves the same cycle.
   assign pushOk    = pushPending && (!fifoFull || pop);

   // FIFO storage; contents need no reset because outputs are gated by valid.
   always_ff @(posedge clock) begin
      if (pushOk) mem[wrPtr] <= {shiftReg, parErr, frmErr};
   end

   // FIFO pointers, occupancy and the overrun pulse.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wrPtr      <= '0;
         rdPtr      <= '0;
         cnt        <= '0;
         overrunReg <= 1'b0;
      end else begin
         overrunReg <= pushPending && !pushOk;
         if (pushOk) wrPtr <= wrPtr + 1'b1;
         if (pop)    rdPtr <= rdPtr + 1'b1;
         case ({pushOk, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   assign headWord       = mem[rdPtr];
   assign bus.data       = fifoValid ? headWord[WIDTH+1:2] : '0;
   assign bus.parity_err = fifoValid & headWord[1];
   assign bus.frame_err  = fifoValid & headWord[0];
   assign bus.valid      = fifoValid;
   assign bus.overrun    = overrunReg;
   assign bus.count      = cnt;
endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb_uart_rx_buffered
// Purpose : directed self-checking bench for uart_rx_buffered. Three
//           instances share one clock: no parity / 1 stop bit, even parity,
//           and 2 stop bits. All use 16 clocks per bit.
module tb_uart_rx_buffered;
   localparam int TICKS = 16;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] rxVec = 3'b111;
   int         total = 0;
   int         bad   = 0;

   logic [9:0] popQ [$];
   int         latQ [$];
   time        stopTime = 0;
   int         ovPulses = 0;

   uart_rx_buffered_if #(.WIDTH(8), .DEPTH(4)) bus0 ();
   uart_rx_buffered_if #(.WIDTH(8), .DEPTH(4)) bus1 ();
   uart_rx_buffered_if #(.WIDTH(8), .DEPTH(4)) bus2 ();

   uart_rx_buffered #(
      .WIDTH(8), .CLOCK_FREQ(16), .BAUD_RATE(1),
      .PARITY(0), .STOP_BITS(1), .DEPTH(4)
   ) u0 (.clock(clock), .reset(reset), .rx(rxVec[0]), .bus(bus0));

   uart_rx_buffered #(
      .WIDTH(8), .CLOCK_FREQ(16), .BAUD_RATE(1),
      .PARITY(1), .STOP_BITS(1), .DEPTH(4)
   ) u1 (.clock(clock), .reset(reset), .rx(rxVec[1]), .bus(bus1));

   uart_rx_buffered #(
      .WIDTH(8), .CLOCK_FREQ(16), .BAUD_RATE(1),
      .PARITY(0), .STOP_BITS(2), .DEPTH(4)
   ) u2 (.clock(clock), .reset(reset), .rx(rxVec[2]), .bus(bus2));

   // Free-running clock, 10 time units per period.
   always #5 clock = ~clock;

   // Records every word popped from the first instance, with the number of
   // clocks since its stop bit began, and counts overrun cycles.
   always @(negedge clock) begin
      if (bus0.valid && bus0.ready) begin
         popQ.push_back({bus0.data, bus0.parity_err, bus0.frame_err});
         latQ.push_back(int'(($time - stopTime) / 10));
      end
      if (bus0.overrun) ovPulses++;
   end

   // Holds one line level for n clocks.
   task automatic bitTime(input int which, input logic value, input int n);
      rxVec[which] = value;
      repeat (n) @(negedge clock);
   endtask

   // Sends one 8-bit frame LSB first; parBit < 0 means no parity bit.
   task automatic applyStimulus(input int which, input logic [7:0] word,
                                input int parBit, input logic stopA,
                                input logic stopB, input int nStop);
      bitTime(which, 1'b0, TICKS);
      for (int i = 0; i < 8; i++) bitTime(which, word[i], TICKS);
      if (parBit >= 0) bitTime(which, parBit[0], TICKS);
      if (which == 0) stopTime = $time;
      bitTime(which, stopA, TICKS);
      if (nStop == 2) bitTime(which, stopB, TICKS);
   endtask

   // One comparison: counts it and reports any difference.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Single pop on the given instance: ready high across exactly one edge.
   task automatic popOne(input int which);
      case (which)
         1:       bus1.ready = 1'b1;
         2:       bus2.ready = 1'b1;
         default: bus0.ready = 1'b1;
      endcase
      @(negedge clock);
      bus0.ready = 1'b0;
      bus1.ready = 1'b0;
      bus2.ready = 1'b0;
   endtask

   initial begin
      int base;
      int ov0;
      bus0.ready = 1'b0;
      bus1.ready = 1'b0;
      bus2.ready = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      $display("[TB] reset state");
      checkOutput("rst_valid",   32'(bus0.valid),      32'd0);
      checkOutput("rst_count",   32'(bus0.count),      32'd0);
      checkOutput("rst_data",    32'(bus0.data),       32'd0);
      checkOutput("rst_perr",    32'(bus0.parity_err), 32'd0);
      checkOutput("rst_ferr",    32'(bus0.frame_err),  32'd0);
      checkOutput("rst_overrun", 32'(bus0.overrun),    32'd0);
      reset = 1'b0;
      repeat (4) @(negedge clock);

      $display("[TB] back-to-back sweep 0x00..0xFF");
      bus0.ready = 1'b1;
      base = popQ.size();
      for (int w = 0; w < 256; w++) applyStimulus(0, 8'(w), -1, 1'b1, 1'b1, 1);
      repeat (40) @(negedge clock);
      checkOutput("sweep_count", 32'(popQ.size() - base), 32'd256);
      for (int w = 0; w < 256; w++) begin
         if (base + w < popQ.size()) begin
            checkOutput($sformatf("sweep_word_%0d", w), 32'(popQ[base + w]), 32'({8'(w), 2'b00}));
            checkOutput($sformatf("sweep_lat_le19_%0d", w), 32'(latQ[base + w] <= TICKS + 3), 32'd1);
         end
      end

      $display("[TB] overrun with ready low");
      bus0.ready = 1'b0;
      ov0 = ovPulses;
      for (int k = 0; k < 5; k++) applyStimulus(0, 8'(8'h11 + k), -1, 1'b1, 1'b1, 1);
      repeat (40) @(negedge clock);
      checkOutput("ovr_count",  32'(bus0.count),     32'd4);
      checkOutput("ovr_pulses", 32'(ovPulses - ov0), 32'd1);
      checkOutput("ovr_head",   32'(bus0.data),      32'h11);
      base = popQ.size();
      bus0.ready = 1'b1;
      repeat (8) @(negedge clock);
      checkOutput("ovr_popped", 32'(popQ.size() - base), 32'd4);
      for (int k = 0; k < 4; k++) begin
         if (base + k < popQ.size())
            checkOutput($sformatf("ovr_order_%0d", k), 32'(popQ[base + k]), 32'({8'(8'h11 + k), 2'b00}));
      end
      checkOutput("ovr_valid_fall", 32'(bus0.valid), 32'd0);
      checkOutput("ovr_count_zero", 32'(bus0.count), 32'd0);

      $display("[TB] break condition");
      base = popQ.size();
      bitTime(0, 1'b0, 20 * TICKS);
      checkOutput("brk_entries", 32'(popQ.size() - base), 32'd1);
      if (popQ.size() > base) checkOutput("brk_word", 32'(popQ[base]), 32'h001);
      bitTime(0, 1'b1, 2 * TICKS);
      checkOutput("brk_no_more", 32'(popQ.size() - base), 32'd1);
      applyStimulus(0, 8'hA5, -1, 1'b1, 1'b1, 1);
      repeat (40) @(negedge clock);
      checkOutput("brk_next_cnt", 32'(popQ.size() - base), 32'd2);
      if (popQ.size() > base + 1) checkOutput("brk_next_word", 32'(popQ[base + 1]), 32'({8'hA5, 2'b00}));

      $display("[TB] glitch rejection");
      base = popQ.size();
      bitTime(0, 1'b0, TICKS / 4);
      bitTime(0, 1'b1, 3 * TICKS);
      checkOutput("glitch_no_push", 32'(popQ.size() - base), 32'd0);
      checkOutput("glitch_count",   32'(bus0.count),         32'd0);
      applyStimulus(0, 8'h5A, -1, 1'b1, 1'b1, 1);
      repeat (40) @(negedge clock);
      checkOutput("glitch_next_cnt", 32'(popQ.size() - base), 32'd1);
      if (popQ.size() > base) checkOutput("glitch_next_word", 32'(popQ[base]), 32'({8'h5A, 2'b00}));

      $display("[TB] reset during a frame");
      bus0.ready = 1'b0;
      applyStimulus(0, 8'h77, -1, 1'b1, 1'b1, 1);
      repeat (40) @(negedge clock);
      checkOutput("mid_pre_count", 32'(bus0.count), 32'd1);
      bitTime(0, 1'b0, TICKS);
      bitTime(0, 1'b0, TICKS);
      bitTime(0, 1'b1, TICKS);
      reset = 1'b1;
      rxVec[0] = 1'b1;
      repeat (2) @(negedge clock);
      checkOutput("mid_rst_valid", 32'(bus0.valid), 32'd0);
      checkOutput("mid_rst_count", 32'(bus0.count), 32'd0);
      reset = 1'b0;
      bus0.ready = 1'b1;
      base = popQ.size();
      repeat (12 * TICKS) @(negedge clock);
      checkOutput("mid_no_push", 32'(popQ.size() - base), 32'd0);
      applyStimulus(0, 8'h3C, -1, 1'b1, 1'b1, 1);
      repeat (40) @(negedge clock);
      checkOutput("mid_next_cnt", 32'(popQ.size() - base), 32'd1);
      if (popQ.size() > base) checkOutput("mid_next_word", 32'(popQ[base]), 32'({8'h3C, 2'b00}));

      $display("[TB] even parity");
      applyStimulus(1, 8'h55, 1, 1'b1, 1'b1, 1);
      repeat (40) @(negedge clock);
      checkOutput("par1_valid", 32'(bus1.valid),      32'd1);
      checkOutput("par1_data",  32'(bus1.data),       32'h55);
      checkOutput("par1_perr",  32'(bus1.parity_err), 32'd1);
      checkOutput("par1_ferr",  32'(bus1.frame_err),  32'd0);
      popOne(1);
      checkOutput("par1_popped", 32'(bus1.valid), 32'd0);
      applyStimulus(1, 8'h55, 0, 1'b1, 1'b1, 1);
      repeat (40) @(negedge clock);
      checkOutput("par0_data", 32'(bus1.data),       32'h55);
      checkOutput("par0_perr", 32'(bus1.parity_err), 32'd0);

      $display("[TB] two stop bits");
      applyStimulus(2, 8'h81, -1, 1'b1, 1'b0, 2);
      rxVec[2] = 1'b1;
      repeat (40) @(negedge clock);
      checkOutput("stop2_valid", 32'(bus2.valid),      32'd1);
      checkOutput("stop2_data",  32'(bus2.data),       32'h81);
      checkOutput("stop2_ferr",  32'(bus2.frame_err),  32'd1);
      checkOutput("stop2_perr",  32'(bus2.parity_err), 32'd0);
      popOne(2);
      applyStimulus(2, 8'h7E, -1, 1'b1, 1'b1, 2);
      repeat (40) @(negedge clock);
      checkOutput("stop2_ok_data", 32'(bus2.data),      32'h7E);
      checkOutput("stop2_ok_ferr", 32'(bus2.frame_err), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uart_rx_buffered.md
UART_RX_BUFFERED -- requirements
Module: uart_rx_buffered

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data bits per frame; legal range 5..9.
REQ-002 SHALL have parameter CLOCK_FREQ, default 460800, meaning clock frequency in Hz.
REQ-003 SHALL have parameter BAUD_RATE, default 9600, meaning line bit rate; TICKS = CLOCK_FREQ/BAUD_RATE, integer, >= 8.
REQ-004 SHALL have parameter PARITY, default 0, meaning parity mode: 0 none, 1 even, 2 odd.
REQ-005 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked; legal values 1 or 2.
REQ-006 SHALL have parameter DEPTH, default 4, meaning FIFO entries; power of two, >= 2.
REQ-007 SHALL have clock  input  1  single clock; all logic on its rising edge.
REQ-008 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-009 SHALL have rx  input  1  asynchronous serial line, idle high.
REQ-010 SHALL have data  output  WIDTH  head-of-FIFO received word.
REQ-011 SHALL have parity_err  output  1  parity error flag of the head entry.
REQ-012 SHALL have frame_err  output  1  stop-bit error flag of the head entry.
REQ-013 SHALL have valid  output  1  FIFO non-empty; head entry presented.
REQ-014 SHALL have ready  input  1  consumer accepts head entry when valid && ready.
REQ-015 SHALL have overrun  output  1  one-cycle pulse when a completed frame is dropped.
REQ-016 SHALL have count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-017 SHALL pass rx through a 2-flop synchronizer (reset value 1); all further references to rx mean the synchronized signal.
REQ-018 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE with a bit-tick counter of $clog2(TICKS) bits.
REQ-019 SHALL leave IDLE for START on the first cycle rx is 0, zeroing the tick counter.
REQ-020 SHALL sample each bit by 2-of-3 majority over counter values TICKS/2-1, TICKS/2, TICKS/2+1, and SHALL advance to the next bit when the counter reaches TICKS-1.
REQ-021 SHALL return START to IDLE without any push if the start-bit majority is 1 (glitch rejection).
REQ-022 SHALL shift DATA bits in LSB first, exactly WIDTH bits, then enter PARITY when PARITY != 0, else STOP.
REQ-023 SHALL set the frame's parity error when the received parity bit differs from the even (PARITY=1) or odd (PARITY=2) parity of the data; SHALL hold it 0 when PARITY=0.
REQ-024 SHALL set the frame's frame error if any of the STOP_BITS stop-bit majorities is 0.
REQ-025 SHALL push {data, parity_err, frame_err} into the FIFO on the cycle after the last stop-bit majority completes (counter TICKS/2+1), then go to IDLE if rx is 1, else to WAIT_IDLE.
REQ-026 SHALL hold WAIT_IDLE (break condition) until rx is 1, then return to IDLE; no frames are received meanwhile.
REQ-027 SHALL assert valid, with head entry visible on data/parity_err/frame_err, on the cycle after a push into an empty FIFO (show-ahead, one-cycle push-to-valid latency).
REQ-028 SHALL pop the head entry on every rising edge where valid && ready; data is don't-care while valid is 0.
REQ-029 SHALL, when full, drop the new frame, keep FIFO contents unchanged and pulse overrun for exactly one cycle.
REQ-030 SHALL, on simultaneous push and pop when full, accept both: count unchanged, no overrun.
REQ-031 SHALL, on simultaneous push and pop otherwise, keep count unchanged; push alone +1, pop alone -1.
REQ-032 SHALL wrap read/write pointers modulo DEPTH; count ranges 0..DEPTH.
REQ-033 SHALL receive back-to-back frames with zero idle between stop bit and next start bit.

Reset
REQ-034 SHALL, while reset is 1, force state IDLE, synchronizer flops 1, counters 0, FIFO pointers and count 0, valid 0, overrun 0, data 0, parity_err 0, frame_err 0.
REQ-035 SHALL abort any frame in progress on reset without a push; reception restarts only on a falling rx after reset deasserts.

Verification
REQ-036 Default parameters, frames 0x00..0xFF, 1 stop bit, ready=1 -> each word on data with valid, parity_err=0, frame_err=0, valid within TICKS+3 clocks of the stop-bit start.
REQ-037 PARITY=1, frame 0x55 with parity bit 1 -> data=0x55, parity_err=1; same with parity bit 0 -> parity_err=0.
REQ-038 DEPTH=4, ready=0, send 5 frames 0x11..0x15 -> count=4, one overrun pulse on the fifth, then ready=1 pops 0x11,0x12,0x13,0x14 in order and valid falls.
REQ-039 rx low for 20 bit times (break) -> one entry data=0x00, frame_err=1; no further entries until rx high, next frame 0xA5 received correctly.
REQ-040 rx low pulse of TICKS/4 clocks -> no push, FSM back in IDLE; reset asserted mid-DATA -> valid=0, count=0, following frame 0x3C received correctly.
REQ-041 STOP_BITS=2, second stop bit 0 on frame 0x81 -> data=0x81, frame_err=1.
